// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD SPI-mode card responder: command indices,
// R1 bit positions, FSM encoding, response lengths and the CRC7 step.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD1  = 6'd1;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD12 = 6'd12;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD18 = 6'd18;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC     = 3;

  localparam logic [5:0] RESP_LEN_R1   = 6'd8;
  localparam logic [5:0] RESP_LEN_LONG = 6'd40;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_RECV,
    ST_DECODE,
    ST_NCR,
    ST_RESP
  } state_t;

  // One MSB-first step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

endpackage

// File: rtl/sd_spi_card_rsp_if.sv
// SPI pins between an SD host (master) and the emulated card (slave).
interface sd_spi_card_rsp_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 engine over the command header bits; only built when
// SD_SPI_CARD_CRC_EN is defined.
`ifdef SD_SPI_CARD_CRC_EN
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic [6:0] w_base;

  // A clear coinciding with an enable seeds the CRC with that first bit.
  assign w_base = i_clr ? 7'h00 : r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 7'h00;
    end else if (i_en) begin
      r_crc <= crc7_step(w_base, i_bit);
    end else if (i_clr) begin
      r_crc <= 7'h00;
    end
  end

  assign o_crc = r_crc;

endmodule
`endif

// File: rtl/sd_spi_card_rsp.sv
// SD-card-side SPI command responder: receives 48-bit frames, tracks the
// idle/init state and returns R1/R3/R7. CRC checking under SD_SPI_CARD_CRC_EN.
module sd_spi_card_rsp
  import sd_spi_pkg::*;
#(
  parameter int          NCR_BYTES = 1,
  parameter int          INIT_CNT  = 2,
  parameter logic [31:0] OCR       = 32'h80FF8000
) (
  input  logic             clk,
  input  logic             rst_n,
  sd_spi_card_rsp_if.slave spi,
  output logic             cmd_valid,
  output logic [5:0]       cmd_idx,
  output logic [31:0]      cmd_arg,
  output logic             card_idle,
  output logic             busy
);

  localparam int               INIT_W   = $clog2(INIT_CNT + 1);
  localparam logic [INIT_W-1:0] INIT_MAX = INIT_W'(INIT_CNT);
  localparam logic [5:0]       NCR_LAST = 6'(NCR_BYTES * 8 - 1);

  state_t              r_state, w_state_nx;
  logic                r_sclk_q;
  logic                w_rise, w_fall;
  logic [5:0]          r_bitcnt, r_ncr_cnt, r_resp_cnt, r_resp_len;
  logic [37:0]         r_hdr;
  logic [39:0]         r_resp;
  logic                r_miso, r_busy, r_cmd_valid, r_card_idle, r_app_cmd;
  logic [5:0]          r_cmd_idx;
  logic [31:0]         r_cmd_arg;
  logic [INIT_W-1:0]   r_init_cnt, w_init_nx;
  logic [5:0]          w_idx;
  logic [31:0]         w_arg, w_payload;
  logic                w_crc_err, w_illegal, w_long, w_idle_nx, w_app_nx;
  logic [7:0]          w_r1;

  assign w_rise = !r_sclk_q && spi.sclk;
  assign w_fall = r_sclk_q && !spi.sclk;

  // r_hdr keeps frame bits 45:8 (index + argument); start/transmission bits are checked, not stored.
  assign w_idx = r_hdr[37:32];
  assign w_arg = r_hdr[31:0];

`ifdef SD_SPI_CARD_CRC_EN
  logic [6:0] r_crc_rx;
  logic [6:0] w_crc;
  logic       w_crc_en;

  assign w_crc_en = w_rise && !spi.cs_n &&
                    ((r_state == ST_HUNT && !spi.mosi) ||
                     (r_state == ST_RECV && r_bitcnt < 6'd40));

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state == ST_HUNT),
    .i_en  (w_crc_en),
    .i_bit (spi.mosi),
    .o_crc (w_crc)
  );

  always_ff @(posedge clk) begin
    if (w_rise && !spi.cs_n && r_state == ST_RECV &&
        r_bitcnt >= 6'd40 && r_bitcnt <= 6'd46) begin
      r_crc_rx <= {r_crc_rx[5:0], spi.mosi};
    end
  end

  assign w_crc_err = ((w_idx == CMD0) || (w_idx == CMD8)) && (w_crc != r_crc_rx);
`else
  assign w_crc_err = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    if (spi.cs_n) begin
      w_state_nx = ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT:   if (w_rise && !spi.mosi) w_state_nx = ST_RECV;
        ST_RECV: begin
          if (w_rise) begin
            if (r_bitcnt == 6'd1 && !spi.mosi) w_state_nx = ST_HUNT;
            else if (r_bitcnt == 6'd47)        w_state_nx = ST_DECODE;
          end
        end
        ST_DECODE: w_state_nx = ST_NCR;
        ST_NCR:    if (w_fall && r_ncr_cnt == NCR_LAST) w_state_nx = ST_RESP;
        ST_RESP:   if (w_fall && r_resp_cnt == r_resp_len) w_state_nx = ST_HUNT;
        default:   w_state_nx = ST_HUNT;
      endcase
    end
  end

  // Command effect and response image, evaluated during DECODE.
  always_comb begin
    w_idle_nx = r_card_idle;
    w_init_nx = r_init_cnt;
    w_app_nx  = 1'b0;
    w_illegal = 1'b0;
    w_long    = 1'b0;
    w_payload = 32'h0;
    case (w_idx)
      CMD0: begin
        if (!w_crc_err) begin
          w_idle_nx = 1'b1;
          w_init_nx = '0;
        end
      end
      CMD8: begin
        w_long    = !w_crc_err;
        w_payload = {20'h0, w_arg[11:0]};
      end
      CMD58: begin
        w_long    = 1'b1;
        w_payload = {!r_card_idle, OCR[30:0]};
      end
      CMD55: w_app_nx = 1'b1;
      CMD41: begin
        if (r_app_cmd) begin
          if (r_init_cnt != INIT_MAX) w_init_nx = r_init_cnt + 1'b1;
          if (w_init_nx == INIT_MAX)  w_idle_nx = 1'b0;
        end else begin
          w_illegal = 1'b1;
        end
      end
      CMD1, CMD12, CMD16, CMD17, CMD18: ;
      default: w_illegal = 1'b1;
    endcase
    w_r1             = 8'h00;
    w_r1[R1_IDLE]    = w_idle_nx;
    w_r1[R1_ILLEGAL] = w_illegal;
    w_r1[R1_CRC]     = w_crc_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_q    <= 1'b1;
      r_state     <= ST_HUNT;
      r_miso      <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_cmd_idx   <= 6'd0;
      r_cmd_arg   <= 32'd0;
      r_card_idle <= 1'b1;
      r_busy      <= 1'b0;
      r_bitcnt    <= 6'd0;
      r_ncr_cnt   <= 6'd0;
      r_resp_cnt  <= 6'd0;
      r_resp_len  <= RESP_LEN_R1;
      r_init_cnt  <= '0;
      r_app_cmd   <= 1'b0;
    end else begin
      r_sclk_q    <= spi.sclk;
      r_state     <= w_state_nx;
      r_cmd_valid <= 1'b0;
      if (spi.cs_n) begin
        r_miso   <= 1'b1;
        r_busy   <= 1'b0;
        r_bitcnt <= 6'd0;
      end else begin
        case (r_state)
          ST_HUNT: if (w_rise && !spi.mosi) r_bitcnt <= 6'd1;
          ST_RECV: if (w_rise) r_bitcnt <= r_bitcnt + 6'd1;
          ST_DECODE: begin
            r_cmd_valid <= 1'b1;
            r_cmd_idx   <= w_idx;
            r_cmd_arg   <= w_arg;
            r_busy      <= 1'b1;
            r_card_idle <= w_idle_nx;
            r_init_cnt  <= w_init_nx;
            r_app_cmd   <= w_app_nx;
            r_resp_len  <= w_long ? RESP_LEN_LONG : RESP_LEN_R1;
            r_ncr_cnt   <= 6'd0;
            r_resp_cnt  <= 6'd0;
          end
          ST_NCR: if (w_fall) r_ncr_cnt <= r_ncr_cnt + 6'd1;
          ST_RESP: begin
            if (w_fall) begin
              if (r_resp_cnt == r_resp_len) begin
                r_miso <= 1'b1;
                r_busy <= 1'b0;
              end else begin
                r_miso     <= r_resp[39];
                r_resp_cnt <= r_resp_cnt + 6'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Data-only registers: header shift and response shift, no reset needed.
  always_ff @(posedge clk) begin
    if (w_rise && !spi.cs_n && r_state == ST_RECV &&
        r_bitcnt >= 6'd2 && r_bitcnt <= 6'd39) begin
      r_hdr <= {r_hdr[36:0], spi.mosi};
    end
    if (r_state == ST_DECODE) begin
      r_resp <= w_long ? {w_r1, w_payload} : {w_r1, 32'h0};
    end else if (r_state == ST_RESP && w_fall && r_resp_cnt != r_resp_len) begin
      r_resp <= {r_resp[38:0], 1'b0};
    end
  end

  assign spi.miso  = r_miso;
  assign cmd_valid = r_cmd_valid;
  assign cmd_idx   = r_cmd_idx;
  assign cmd_arg   = r_cmd_arg;
  assign card_idle = r_card_idle;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sd_spi_card_rsp.sv
// Self-checking bench for sd_spi_card_rsp: directed command sequences plus
// randomized commands checked against a command-level card model.
module tb_sd_spi_card_rsp;

  localparam int          NCR_BYTES = 1;
  localparam int          INIT_CNT  = 2;
  localparam logic [31:0] OCR       = 32'h80FF8000;
`ifdef SD_SPI_CARD_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_spi_card_rsp_if spi();
  logic        cmd_valid;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        card_idle;
  logic        busy;

  sd_spi_card_rsp #(.NCR_BYTES(NCR_BYTES), .INIT_CNT(INIT_CNT), .OCR(OCR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi),
    .cmd_valid (cmd_valid),
    .cmd_idx   (cmd_idx),
    .cmd_arg   (cmd_arg),
    .card_idle (card_idle),
    .busy      (busy)
  );

  int n_pass  = 0;
  int n_total = 0;
  int H = 3;

  // card model state
  bit          m_idle = 1'b1;
  int          m_init = 0;
  bit          m_app  = 1'b0;
  bit          m_pending = 1'b0;
  logic [5:0]  m_exp_idx;
  logic [31:0] m_exp_arg;
  bit          m_exp_bad;
  logic [39:0] m_resp;
  int          m_len = 8;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic model_step(input logic [5:0] idx, input logic [31:0] arg, input bit bad);
    bit legal, crcerr;
    logic [7:0] r1;
    legal  = (idx inside {6'd0, 6'd1, 6'd8, 6'd12, 6'd16, 6'd17, 6'd18, 6'd55, 6'd58}) ||
             (idx == 6'd41 && m_app);
    crcerr = CRC_EN && bad && (idx == 6'd0 || idx == 6'd8);
    if (legal && !crcerr) begin
      if (idx == 6'd0) begin
        m_idle = 1'b1;
        m_init = 0;
      end
      if (idx == 6'd41) begin
        if (m_init < INIT_CNT) m_init++;
        if (m_init == INIT_CNT) m_idle = 1'b0;
      end
    end
    m_app = (idx == 6'd55);
    r1 = {4'b0000, crcerr, !legal, 1'b0, m_idle};
    if (idx == 6'd8 && !crcerr) begin
      m_len  = 40;
      m_resp = {r1, 20'h0, arg[11:0]};
    end else if (idx == 6'd58) begin
      m_len  = 40;
      m_resp = {r1, !m_idle, OCR[30:0]};
    end else begin
      m_len  = 8;
      m_resp = {r1, 32'h0};
    end
  endtask

  // Compare process: command pulses and idle flag every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        if (!m_pending) begin
          n_total++;
          $display("FAIL unexpected_cmd_valid: got 1 expected 0 (idx %0d)", cmd_idx);
        end else begin
          chk("cmd_idx", cmd_idx, m_exp_idx);
          chk("cmd_arg", cmd_arg, m_exp_arg);
          model_step(m_exp_idx, m_exp_arg, m_exp_bad);
          m_pending = 1'b0;
        end
      end
      chk("card_idle", card_idle, m_idle);
    end
  end

  task automatic sbit(input logic b, output logic so);
    spi.mosi = b;
    repeat (H) @(negedge clk);
    so = spi.miso;
    spi.sclk = 1'b1;
    repeat (H) @(negedge clk);
    spi.sclk = 1'b0;
  endtask

  task automatic xact(input logic [5:0] idx, input logic [31:0] arg, input bit bad,
                      output logic [39:0] got);
    logic [47:0] fr;
    logic [6:0]  c;
    logic [39:0] exp;
    logic        so;
    int          tot;
    c = crc7({2'b01, idx, arg});
    if (bad) c = c ^ 7'h01;
    fr = {2'b01, idx, arg, c, 1'b1};
    m_exp_idx = idx;
    m_exp_arg = arg;
    m_exp_bad = bad;
    m_pending = 1'b1;
    for (int i = 47; i >= 1; i--) sbit(fr[i], so);
    spi.mosi = fr[0];
    repeat (H) @(negedge clk);
    spi.sclk = 1'b1;
    repeat (H) @(negedge clk);
    chk("busy_after_frame", busy, 1);
    spi.sclk = 1'b0;
    if (m_pending) begin
      n_total++;
      $display("FAIL missing_cmd_valid: got 0 expected 1 (idx %0d)", idx);
      model_step(idx, arg, bad);
      m_pending = 1'b0;
    end
    got = '0;
    tot = NCR_BYTES * 8 + m_len;
    for (int k = 0; k < tot; k++) begin
      spi.mosi = 1'($urandom);
      repeat (H) @(negedge clk);
      so = spi.miso;
      if (k < NCR_BYTES * 8) chk("ncr_fill", so, 1);
      else got = {got[38:0], so};
      spi.sclk = 1'b1;
      repeat (H) @(negedge clk);
      if (k == tot - 1) chk("busy_last_bit", busy, 1);
      spi.sclk = 1'b0;
    end
    spi.mosi = 1'b1;
    exp = (m_len == 8) ? {32'h0, m_resp[39:32]} : m_resp;
    chk("response", got, exp);
    repeat (2) @(negedge clk);
    chk("busy_end", busy, 0);
    chk("miso_idle", spi.miso, 1);
  endtask

  task automatic partial(input int n);
    logic [47:0] fr;
    logic        so;
    fr = {2'b01, 6'($urandom), 32'($urandom), 7'h00, 1'b1};
    for (int i = 47; i >= 48 - n; i--) sbit(fr[i], so);
    spi.mosi = 1'b1;
    spi.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_miso", spi.miso, 1);
    spi.cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic init_seq();
    logic [39:0] g;
    for (int i = 0; i < 2 * INIT_CNT; i++)
      xact((i % 2) ? 6'd41 : 6'd55, (i % 2) ? 32'h40000000 : 32'h0, 1'b0, g);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [39:0] g;
  logic [7:0]  seq [4] = '{8'h01, 8'h01, 8'h01, 8'h00};
  logic [5:0]  ctab [15] = '{6'd0, 6'd1, 6'd5, 6'd8, 6'd12, 6'd16, 6'd17, 6'd18,
                             6'd41, 6'd41, 6'd55, 6'd55, 6'd58, 6'd63, 6'd2};

  initial begin
    logic [5:0]  ridx;
    logic [31:0] rarg;
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    spi.mosi = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_miso", spi.miso, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_idx", cmd_idx, 0);
    chk("rst_cmd_arg", cmd_arg, 0);
    chk("rst_card_idle", card_idle, 1);
    chk("rst_busy", busy, 0);
    chk("model_crc_cmd0", crc7(40'h4000000000), 7'h4A);
    chk("model_crc_cmd8", crc7(40'h48000001AA), 7'h43);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    spi.cs_n = 1'b0;
    repeat (2) @(negedge clk);

    xact(6'd0, 32'h0, 1'b0, g);          chk("cmd0_r1", g, 40'h01);
    xact(6'd8, 32'h000001AA, 1'b0, g);   chk("cmd8_r7", g, 40'h01000001AA);
    xact(6'd5, 32'h0, 1'b0, g);          chk("cmd5_r1", g, 40'h05);
    chk("cmd5_idle", card_idle, 1);
    for (int i = 0; i < 4; i++) begin
      xact((i % 2) ? 6'd41 : 6'd55, (i % 2) ? 32'h40000000 : 32'h0, 1'b0, g);
      chk("acmd41_seq", g, {32'h0, seq[i]});
    end
    chk("init_idle", card_idle, 0);
    xact(6'd58, 32'h0, 1'b0, g);         chk("cmd58_r3", g, 40'h0080FF8000);
    partial(20);
    xact(6'd0, 32'h0, 1'b0, g);          chk("cmd0_after_abort", g, 40'h01);

    init_seq();
    xact(6'd0, 32'h0, 1'b1, g);
    chk("cmd0_badcrc_r1", g, CRC_EN ? 40'h08 : 40'h01);
    chk("cmd0_badcrc_idle", card_idle, CRC_EN ? 0 : 1);

    for (int t = 0; t < 30; t++) begin
      H = $urandom_range(3, 4);
      if ($urandom_range(0, 7) == 0) partial($urandom_range(1, 47));
      ridx = ctab[$urandom_range(0, 14)];
      rarg = $urandom;
      if (ridx == 6'd8 && $urandom_range(0, 1) == 1) rarg = {20'h0, 4'h1, 8'($urandom)};
      xact(ridx, rarg, ($urandom_range(0, 5) == 0), g);
    end

    H = 3;
    init_seq();
    begin
      logic [47:0] fr;
      logic        so;
      fr = {2'b01, 6'd17, 32'h12345678, 7'h00, 1'b1};
      for (int i = 47; i >= 18; i--) sbit(fr[i], so);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_miso", spi.miso, 1);
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_cmd_idx", cmd_idx, 0);
    chk("midrst_cmd_arg", cmd_arg, 0);
    chk("midrst_card_idle", card_idle, 1);
    chk("midrst_busy", busy, 0);
    m_idle = 1'b1;
    m_init = 0;
    m_app  = 1'b0;
    m_pending = 1'b0;
    spi.mosi = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    xact(6'd0, 32'h0, 1'b0, g);          chk("cmd0_after_reset", g, 40'h01);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
